// File: rtl/collision_score_if.sv
`default_nettype none
// ============================================================================
// Module      : collision_score_if
// Description : Game-state bus between the pipe movers / bird logic and the
//               collision_score block. The hi_score member exists only when
//               COLLISION_SCORE_HISCORE_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface collision_score_if;
    logic        start;
    logic [9:0]  bird_pos_y;
    logic [9:0]  pipe_pos_x_a;
    logic [9:0]  pipe_pos_y_a;
    logic [9:0]  pipe_pos_x_b;
    logic [9:0]  pipe_pos_y_b;
    logic        lost;
    logic        playing;
    logic        score_tick;
    logic [11:0] score;
`ifdef COLLISION_SCORE_HISCORE_EN
    logic [11:0] hi_score;

    // Game-logic side: supplies positions and start, observes game state.
    modport master (
        output start, bird_pos_y, pipe_pos_x_a, pipe_pos_y_a,
               pipe_pos_x_b, pipe_pos_y_b,
        input  lost, playing, score_tick, score, hi_score
    );

    // collision_score side.
    modport slave (
        input  start, bird_pos_y, pipe_pos_x_a, pipe_pos_y_a,
               pipe_pos_x_b, pipe_pos_y_b,
        output lost, playing, score_tick, score, hi_score
    );
`else
    // Game-logic side: supplies positions and start, observes game state.
    modport master (
        output start, bird_pos_y, pipe_pos_x_a, pipe_pos_y_a,
               pipe_pos_x_b, pipe_pos_y_b,
        input  lost, playing, score_tick, score
    );

    // collision_score side.
    modport slave (
        input  start, bird_pos_y, pipe_pos_x_a, pipe_pos_y_a,
               pipe_pos_x_b, pipe_pos_y_b,
        output lost, playing, score_tick, score
    );
`endif
endinterface
`default_nettype wire

// File: rtl/collision_score.sv
`default_nettype none
// ============================================================================
// Module      : collision_score
// Description : Bird/pipe and bird/floor collision detection, pipe-pass
//               counting, IDLE/PLAY/LOST game state machine and a saturating
//               3-digit BCD score. Optional hi-score register is enabled by
//               defining COLLISION_SCORE_HISCORE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module collision_score #(
    parameter int BIRD_X     = 100,
    parameter int BIRD_SIZE  = 20,
    parameter int PIPE_WIDTH = 60,
    parameter int GAP_HEIGHT = 150,
    parameter int FLOOR_Y    = 460
) (
    input  wire logic         clk,
    input  wire logic         reset_n,
    collision_score_if.slave  bus
);

    // Geometry constants, all in 11 bits so sums of 10-bit positions and
    // sizes can never wrap.
    localparam logic [10:0] BIRD_LEFT  = 11'(BIRD_X);
    localparam logic [10:0] BIRD_RIGHT = 11'(BIRD_X + BIRD_SIZE);
    localparam logic [10:0] BIRD_H     = 11'(BIRD_SIZE);
    localparam logic [10:0] PIPE_W     = 11'(PIPE_WIDTH);
    localparam logic [10:0] GAP_H      = 11'(GAP_HEIGHT);
    localparam logic [10:0] FLOOR_LINE = 11'(FLOOR_Y);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] PLAY = 2'd1;
    localparam logic [1:0] LOST = 2'd2;

    logic [1:0]  state;
    logic [1:0]  next_state;
    logic        lost_q;
    logic        playing_q;
    logic        tick_q;
    logic [11:0] score_q;
    logic        passed_a;
    logic        passed_b;

    logic [10:0] bird_top;
    logic [10:0] bird_bot;
    logic [10:0] xa_left;
    logic [10:0] xa_right;
    logic [10:0] ya_top;
    logic [10:0] ya_bot;
    logic [10:0] xb_left;
    logic [10:0] xb_right;
    logic [10:0] yb_top;
    logic [10:0] yb_bot;
    logic        overlap_a;
    logic        overlap_b;
    logic        hit_a;
    logic        hit_b;
    logic        floor_hit;
    logic        collision;
    logic        behind_a;
    logic        behind_b;
    logic        event_a;
    logic        event_b;

    logic        score_clear;
    logic [1:0]  score_inc;

    // ------------------------------------------------------------------
    // Geometry
    // ------------------------------------------------------------------
    assign bird_top = {1'b0, bus.bird_pos_y};
    assign bird_bot = bird_top + BIRD_H;
    assign xa_left  = {1'b0, bus.pipe_pos_x_a};
    assign xa_right = xa_left + PIPE_W;
    assign ya_top   = {1'b0, bus.pipe_pos_y_a};
    assign ya_bot   = ya_top + GAP_H;
    assign xb_left  = {1'b0, bus.pipe_pos_x_b};
    assign xb_right = xb_left + PIPE_W;
    assign yb_top   = {1'b0, bus.pipe_pos_y_b};
    assign yb_bot   = yb_top + GAP_H;

    assign overlap_a = (xa_left < BIRD_RIGHT) && (xa_right > BIRD_LEFT);
    assign overlap_b = (xb_left < BIRD_RIGHT) && (xb_right > BIRD_LEFT);
    assign hit_a     = overlap_a && ((bird_top < ya_top) || (bird_bot > ya_bot));
    assign hit_b     = overlap_b && ((bird_top < yb_top) || (bird_bot > yb_bot));
    assign floor_hit = (bird_bot >= FLOOR_LINE);
    assign collision = hit_a || hit_b || floor_hit;

    // A pipe is "behind" once its right edge is strictly left of the bird.
    assign behind_a = (xa_right < BIRD_LEFT);
    assign behind_b = (xb_right < BIRD_LEFT);
    assign event_a  = behind_a && !passed_a;
    assign event_b  = behind_b && !passed_b;

    // Pass flags follow pipe position in every state, so a pipe that wraps
    // back to the right edge re-arms and each pass is counted once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            passed_a <= 1'b1;
            passed_b <= 1'b1;
        end else begin
            if (!behind_a)
                passed_a <= 1'b0;
            else if (event_a)
                passed_a <= 1'b1;
            if (!behind_b)
                passed_b <= 1'b0;
            else if (event_b)
                passed_b <= 1'b1;
        end
    end

    // Saturating BCD add of 0..2; ripple carry per digit, clamp at 999.
    function automatic logic [11:0] bcd_sat_add(input logic [11:0] v,
                                                input logic [1:0]  inc);
        logic [4:0] s0;
        logic [4:0] s1;
        logic [4:0] s2;
        logic       c0;
        logic       c1;
        logic [3:0] d0;
        logic [3:0] d1;
        s0 = {1'b0, v[3:0]} + {3'b000, inc};
        c0 = (s0 > 5'd9);
        d0 = c0 ? 4'(s0 - 5'd10) : s0[3:0];
        s1 = {1'b0, v[7:4]} + {4'b0000, c0};
        c1 = (s1 > 5'd9);
        d1 = c1 ? 4'(s1 - 5'd10) : s1[3:0];
        s2 = {1'b0, v[11:8]} + {4'b0000, c1};
        if (s2 > 5'd9)
            bcd_sat_add = 12'h999;
        else
            bcd_sat_add = {s2[3:0], d1, d0};
    endfunction

    // ------------------------------------------------------------------
    // Game state machine
    // ------------------------------------------------------------------

    // State register plus registered Lost/Playing decoded from next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            lost_q    <= 1'b0;
            playing_q <= 1'b0;
        end else begin
            state     <= next_state;
            lost_q    <= (next_state == LOST);
            playing_q <= (next_state == PLAY);
        end
    end

    // Next-state logic: Start leaves IDLE and LOST, a collision ends PLAY.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.start) next_state = PLAY;
            PLAY:    if (collision) next_state = LOST;
            LOST:    if (bus.start) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Score control: clear on game start, count passes only in a
    // collision-free PLAY cycle.
    always_comb begin
        score_clear = 1'b0;
        score_inc   = 2'd0;
        case (state)
            IDLE:    score_clear = bus.start;
            PLAY:    if (!collision)
                         score_inc = {1'b0, event_a} + {1'b0, event_b};
            default: ;
        endcase
    end

    // Score register and one-cycle tick on every nonzero add.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            score_q <= 12'h000;
            tick_q  <= 1'b0;
        end else begin
            tick_q <= (score_inc != 2'd0);
            if (score_clear)
                score_q <= 12'h000;
            else if (score_inc != 2'd0)
                score_q <= bcd_sat_add(score_q, score_inc);
        end
    end

`ifdef COLLISION_SCORE_HISCORE_EN
    logic [11:0] hi_q;

    // Capture the final score of a game if it beats the best so far;
    // packed BCD orders the same as the numeric value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            hi_q <= 12'h000;
        else if ((state == PLAY) && collision && (score_q > hi_q))
            hi_q <= score_q;
    end

    assign bus.hi_score = hi_q;
`endif

    assign bus.lost       = lost_q;
    assign bus.playing    = playing_q;
    assign bus.score_tick = tick_q;
    assign bus.score      = score_q;

endmodule
`default_nettype wire
